hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//   Hazard controller for the 5-stage RV32 pipeline without forwarding. Compares ID source regs against the
//   EX/MEM/WB destinations, inserts bubbles by driving Data_stall into the ID/EX latch flush and freezing PC and IF/ID.
//   Squashes IF/ID and ID/EX when EX redirects (taken branch/jump). Keeps saturating stall/flush statistics counters.
// PARAMETERS
//   RF_WRITE_THROUGH  1  1: regfile write in WB is visible to ID read in the same cycle; 0: not visible
//   STAT_W            16 width of statistics counters
// PORTS
//   clk           in   1       system clock, all state on posedge
//   rst           in   1       asynchronous, active-low reset
//   ID_rs1        in   5       rs1 field of instruction in ID
//   ID_rs2        in   5       rs2 field of instruction in ID
//   ID_rs1_used   in   1       ID instruction reads rs1
//   ID_rs2_used   in   1       ID instruction reads rs2
//   EX_rd         in   5       destination in EX;  EX_RegWrite  in 1  its write enable
//   MEM_rd        in   5       destination in MEM; MEM_RegWrite in 1  its write enable
//   WB_rd         in   5       destination in WB;  WB_RegWrite  in 1  its write enable
//   EX_redirect   in   1       EX resolved taken branch or jump this cycle
//   PC_EN         out  1       PC update enable
//   IFID_EN       out  1       IF/ID latch enable
//   IFID_flush    out  1       IF/ID latch loads NOP
//   Data_stall    out  1       ID/EX flush (bubble insert)
//   stall_cycles  out  STAT_W  saturating count of cycles with Data_stall=1 caused by data hazards
//   redirect_cnt  out  STAT_W  saturating count of EX_redirect events
// BEHAVIOUR
//   Match: hit_X = X_RegWrite & (X_rd!=0) & ((ID_rs1_used & ID_rs1==X_rd) | (ID_rs2_used & ID_rs2==X_rd)).
//   Bubbles needed N: hit_EX -> 2+W, else hit_MEM -> 1+W, else hit_WB -> W, else 0; W = (RF_WRITE_THROUGH?0:1).
//   FSM states RUN, STALL; 2-bit down-counter cnt.
//   RUN: if EX_redirect: IFID_flush=1, Data_stall=1, PC_EN=1, IFID_EN=1; redirect_cnt++; stay RUN.
//        else if N>0: Data_stall=1, PC_EN=0, IFID_EN=0; stall_cycles++; if N>1 {cnt<=N-1; ->STALL} else stay RUN.
//        else: PC_EN=1, IFID_EN=1, IFID_flush=0, Data_stall=0.
//   STALL: hazard compare ignored; Data_stall=1, PC_EN=0, IFID_EN=0; stall_cycles++; cnt<=cnt-1;
//        when cnt==1 at the edge -> RUN. EX_redirect in STALL (cannot occur, since EX holds a bubble)
//        takes redirect priority: outputs as RUN-redirect, cnt<=0, ->RUN, redirect_cnt++, no stall_cycles++.
//   Priority: redirect > data hazard. x0 never causes a hazard.
//   Outputs are combinational from state and inputs; no added latency: a hazard seen in cycle t freezes PC at edge t+1.
//   Counters saturate at all-ones and never wrap.
//   Reset (rst=0, async): state=RUN, cnt=0, stall_cycles=0, redirect_cnt=0. While rst=0 force PC_EN=1,
//   IFID_EN=1, IFID_flush=0, Data_stall=0 regardless of inputs. Reset mid-STALL aborts the stall immediately.
// TESTING
//   1 RF_WRITE_THROUGH=1: ID rs1=5 used, EX_rd=5 EX_RegWrite=1 -> Data_stall=1, PC_EN=0 for exactly 2 cycles
//     (state STALL for 1 cycle), then PC_EN=1; stall_cycles=2.
//   2 rs2=7 used, MEM_rd=7 MEM_RegWrite=1 -> 1 bubble, stay RUN; with RF_WRITE_THROUGH=0 -> 2 bubbles.
//   3 EX_rd=0 EX_RegWrite=1 and rs1=0 used -> no stall; EX_rd=5 EX_RegWrite=0 -> no stall;
//     rs1=5 with ID_rs1_used=0 -> no stall.
//   4 EX_redirect=1 together with hit_EX -> IFID_flush=1, Data_stall=1, PC_EN=1 for 1 cycle;
//     redirect_cnt+1, stall_cycles unchanged.
//   5 Drop rst to 0 during STALL -> outputs immediately PC_EN=1, Data_stall=0; counters=0; after release, state RUN.
//   6 Preload stall_cycles near 0xFFFF via repeated hazards -> the value holds at 0xFFFF, no wrap to 0.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: pipeline hazard bus; master drives ID/EX/MEM/WB register info and redirect, slave returns enables and stats
interface hazard_stall_ctrl_if #(parameter int STAT_W = 16);
  logic [4:0] ID_rs1, ID_rs2, EX_rd, MEM_rd, WB_rd;
  logic ID_rs1_used, ID_rs2_used, EX_RegWrite, MEM_RegWrite, WB_RegWrite, EX_redirect;
  logic PC_EN, IFID_EN, IFID_flush, Data_stall;
  logic [STAT_W-1:0] stall_cycles, redirect_cnt;
  modport master (
    output ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, EX_rd, EX_RegWrite, MEM_rd, MEM_RegWrite,
           WB_rd, WB_RegWrite, EX_redirect,
    input  PC_EN, IFID_EN, IFID_flush, Data_stall, stall_cycles, redirect_cnt
  );
  modport slave (
    input  ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, EX_rd, EX_RegWrite, MEM_rd, MEM_RegWrite,
           WB_rd, WB_RegWrite, EX_redirect,
    output PC_EN, IFID_EN, IFID_flush, Data_stall, stall_cycles, redirect_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: no-forwarding RV32 hazard unit; stalls PC/IF-ID and inserts ID/EX bubbles, squashes on redirect
//   clk, rst (async, active-low); bus.slave: ID sources, EX/MEM/WB destinations, EX_redirect in;
//   PC_EN, IFID_EN, IFID_flush, Data_stall, stall_cycles, redirect_cnt out
module hazard_stall_ctrl #(
  parameter bit RF_WRITE_THROUGH = 1'b1,
  parameter int STAT_W           = 16
) (
  input logic clk,
  input logic rst,
  hazard_stall_ctrl_if.slave bus
);
  typedef enum logic {RUN, STALL} state_t;
  localparam logic [1:0] W = RF_WRITE_THROUGH ? 2'd0 : 2'd1;
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d, n;
  logic [STAT_W-1:0] stall_cycles_q, stall_cycles_d, redirect_cnt_q, redirect_cnt_d;
  logic hit_ex, hit_mem, hit_wb, pc_en, ifid_en, flush, stall, inc_stall, inc_redir;
  function automatic logic hit(input logic [4:0] rd, input logic we, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2);
    return we && rd != 5'd0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
  endfunction
  assign hit_ex  = hit(bus.EX_rd, bus.EX_RegWrite, bus.ID_rs1, bus.ID_rs2, bus.ID_rs1_used, bus.ID_rs2_used);
  assign hit_mem = hit(bus.MEM_rd, bus.MEM_RegWrite, bus.ID_rs1, bus.ID_rs2, bus.ID_rs1_used, bus.ID_rs2_used);
  assign hit_wb  = hit(bus.WB_rd, bus.WB_RegWrite, bus.ID_rs1, bus.ID_rs2, bus.ID_rs1_used, bus.ID_rs2_used);
  assign n = hit_ex ? 2'd2 + W : hit_mem ? 2'd1 + W : hit_wb ? W : 2'd0;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    flush     = 1'b0;
    stall     = 1'b0;
    inc_stall = 1'b0;
    inc_redir = 1'b0;
    if (bus.EX_redirect) begin
      flush     = 1'b1;
      stall     = 1'b1;
      inc_redir = 1'b1;
      cnt_d     = 2'd0;
      state_d   = RUN;
    end else if (state_q == STALL || n != 2'd0) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      stall     = 1'b1;
      inc_stall = 1'b1;
      cnt_d     = state_q == STALL ? cnt_q - 2'd1 : (n > 2'd1 ? n - 2'd1 : cnt_q);
      state_d   = state_q == STALL ? (cnt_q == 2'd1 ? RUN : STALL) : (n > 2'd1 ? STALL : RUN);
    end
    stall_cycles_d = (inc_stall && !(&stall_cycles_q)) ? stall_cycles_q + 1'b1 : stall_cycles_q;
    redirect_cnt_d = (inc_redir && !(&redirect_cnt_q)) ? redirect_cnt_q + 1'b1 : redirect_cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= RUN;
      cnt_q          <= 2'd0;
      stall_cycles_q <= '0;
      redirect_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end
  // reset overrides the pipeline controls combinationally so the pipeline runs freely while held in reset
  assign bus.PC_EN        = pc_en | ~rst;
  assign bus.IFID_EN      = ifid_en | ~rst;
  assign bus.IFID_flush   = flush & rst;
  assign bus.Data_stall   = stall & rst;
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.redirect_cnt = redirect_cnt_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: scoreboard bench for write-through and non-write-through hazard controllers
module tb_hazard_stall_ctrl;
  localparam int SW = 16;
  localparam int MAXC = (1 << SW) - 1;
  typedef struct packed {
    logic [4:0] rs1, rs2;
    logic u1, u2;
    logic [4:0] exrd;
    logic exw;
    logic [4:0] memrd;
    logic memw;
    logic [4:0] wbrd;
    logic wbw, redir;
  } inp_t;
  typedef struct packed {
    logic pc, ifid, fl, ds;
    logic [SW-1:0] sc, rc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  int rem[2], sc[2], rc[2];
  exp_t q0[$], q1[$];
  hazard_stall_ctrl_if #(.STAT_W(SW)) bus0 ();
  hazard_stall_ctrl_if #(.STAT_W(SW)) bus1 ();
  hazard_stall_ctrl #(.RF_WRITE_THROUGH(1'b1), .STAT_W(SW)) u_wt (.clk(clk), .rst(rst), .bus(bus0));
  hazard_stall_ctrl #(.RF_WRITE_THROUGH(1'b0), .STAT_W(SW)) u_nwt (.clk(clk), .rst(rst), .bus(bus1));
  always #5 clk = ~clk;
  function automatic inp_t mk(int rs1, int rs2, int u1, int u2, int exrd, int exw, int memrd, int memw,
                              int wbrd, int wbw, int redir);
    inp_t v;
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = 1'(u1); v.u2 = 1'(u2);
    v.exrd = 5'(exrd); v.exw = 1'(exw); v.memrd = 5'(memrd); v.memw = 1'(memw);
    v.wbrd = 5'(wbrd); v.wbw = 1'(wbw); v.redir = 1'(redir);
    return v;
  endfunction
  function automatic bit reads(inp_t v, logic [4:0] rd, logic we);
    return we && rd != 0 && ((v.u1 && v.rs1 == rd) || (v.u2 && v.rs2 == rd));
  endfunction
  // bubbles an instruction in ID must wait: its producer needs to reach the point where ID can read it
  function automatic int bubbles(inp_t v, int w);
    if (reads(v, v.exrd, v.exw)) return 2 + w;
    if (reads(v, v.memrd, v.memw)) return 1 + w;
    if (reads(v, v.wbrd, v.wbw)) return w;
    return 0;
  endfunction
  function automatic int sat(int x);
    return x >= MAXC ? MAXC : x + 1;
  endfunction
  task automatic model(input int k, input logic r, input inp_t v, output exp_t e);
    int need;
    e = '{pc: 1'b1, ifid: 1'b1, fl: 1'b0, ds: 1'b0, sc: SW'(sc[k]), rc: SW'(rc[k])};
    if (!r) begin
      rem[k] = 0; sc[k] = 0; rc[k] = 0;
      e.sc = '0; e.rc = '0;
    end else if (v.redir) begin
      e.fl = 1'b1; e.ds = 1'b1;
      rem[k] = 0;
      rc[k] = sat(rc[k]);
    end else begin
      need = rem[k] > 0 ? rem[k] : bubbles(v, k == 0 ? 0 : 1);
      if (need > 0) begin
        e.pc = 1'b0; e.ifid = 1'b0; e.ds = 1'b1;
        sc[k] = sat(sc[k]);
        rem[k] = need - 1;
      end
    end
  endtask
  task automatic drive(input inp_t v);
    bus0.ID_rs1 = v.rs1; bus0.ID_rs2 = v.rs2; bus0.ID_rs1_used = v.u1; bus0.ID_rs2_used = v.u2;
    bus0.EX_rd = v.exrd; bus0.EX_RegWrite = v.exw; bus0.MEM_rd = v.memrd; bus0.MEM_RegWrite = v.memw;
    bus0.WB_rd = v.wbrd; bus0.WB_RegWrite = v.wbw; bus0.EX_redirect = v.redir;
    bus1.ID_rs1 = v.rs1; bus1.ID_rs2 = v.rs2; bus1.ID_rs1_used = v.u1; bus1.ID_rs2_used = v.u2;
    bus1.EX_rd = v.exrd; bus1.EX_RegWrite = v.exw; bus1.MEM_rd = v.memrd; bus1.MEM_RegWrite = v.memw;
    bus1.WB_rd = v.wbrd; bus1.WB_RegWrite = v.wbw; bus1.EX_redirect = v.redir;
  endtask
  task automatic step(input logic r, input inp_t v);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    drive(v);
    model(0, r, v, e); q0.push_back(e);
    model(1, r, v, e); q1.push_back(e);
  endtask
  task automatic chk(input string name, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h want %0h at %0t", name, k, act, exp, $time);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q0.size() > 0) begin
        e = q0.pop_front();
        chk("PC_EN", 0, int'(bus0.PC_EN), int'(e.pc));
        chk("IFID_EN", 0, int'(bus0.IFID_EN), int'(e.ifid));
        chk("IFID_flush", 0, int'(bus0.IFID_flush), int'(e.fl));
        chk("Data_stall", 0, int'(bus0.Data_stall), int'(e.ds));
        chk("stall_cycles", 0, int'(bus0.stall_cycles), int'(e.sc));
        chk("redirect_cnt", 0, int'(bus0.redirect_cnt), int'(e.rc));
      end
      while (q1.size() > 0) begin
        e = q1.pop_front();
        chk("PC_EN", 1, int'(bus1.PC_EN), int'(e.pc));
        chk("IFID_EN", 1, int'(bus1.IFID_EN), int'(e.ifid));
        chk("IFID_flush", 1, int'(bus1.IFID_flush), int'(e.fl));
        chk("Data_stall", 1, int'(bus1.Data_stall), int'(e.ds));
        chk("stall_cycles", 1, int'(bus1.stall_cycles), int'(e.sc));
        chk("redirect_cnt", 1, int'(bus1.redirect_cnt), int'(e.rc));
      end
    end
  end
  initial begin
    inp_t idle, haz;
    idle = '0;
    haz = mk(5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0);
    drive(idle);
    rem = '{0, 0}; sc = '{0, 0}; rc = '{0, 0};
    repeat (2) step(1'b0, haz);
    repeat (2) step(1'b1, idle);
    step(1'b1, haz);
    repeat (3) step(1'b1, idle);
    step(1'b1, mk(0, 7, 0, 1, 0, 0, 7, 1, 0, 0, 0));
    repeat (3) step(1'b1, idle);
    step(1'b1, mk(3, 0, 1, 0, 0, 0, 0, 0, 3, 1, 0));
    repeat (2) step(1'b1, idle);
    step(1'b1, mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    step(1'b1, mk(5, 0, 1, 0, 5, 0, 0, 0, 0, 0, 0));
    step(1'b1, mk(5, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0));
    step(1'b1, mk(5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 1));
    repeat (3) step(1'b1, idle);
    step(1'b1, haz);
    step(1'b0, idle);
    repeat (3) step(1'b1, idle);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) != 0,
           mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
              $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 9) == 0));
    step(1'b0, idle);
    for (int i = 0; i < MAXC + 4; i++) step(1'b1, haz);
    step(1'b1, mk(5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 1));
    repeat (3) step(1'b1, idle);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
